mem_arbiter_ws: RTL and testbench

Parametrised successor to the fixed fetch/memory-stage controller: arbitrates the pipeline's fetch port and memory-stage port onto a single byte-lane RAM with a configurable number of wait states. Selectable fixed or round-robin priority, per-lane write enables and a registered four-phase-free req/ack handshake. Sits between the Mips core and the Ram model; the core stalls on its stall outputs.

---
 rtl/mem_arbiter_ws_if.sv | 41 ++++
 rtl/mem_arbiter_ws.sv | 119 +++++++++++
 tb/tb_mem_arbiter_ws.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_ws_if.sv
// Signal bundle between mem_arbiter_ws, the fetch and memory-stage requesters, and the byte-lane RAM.
// The slave modport is the arbiter's view; master is the core/RAM side.
interface mem_arbiter_ws_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_stall;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rw;
  logic [LANES-1:0]  ram_en;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, mem_be, ram_rdata,
    output if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_addr, ram_rw, ram_en, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, mem_be, ram_rdata,
    input  if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_addr, ram_rw, ram_en, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter_ws.sv
// Two-port (fetch / memory-stage) arbiter onto one byte-lane RAM with WAIT_STATES extra access cycles.
// Fixed (memory wins) or round-robin priority; one access per WAIT_STATES+3 cycles.

module mem_arbiter_ws_lane (
  input  logic access,
  input  logic wr,
  input  logic be,
  output logic en
);
  // Reads light every lane; writes only the byte-enabled ones.
  assign en = access & (~wr | be);
endmodule

module mem_arbiter_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 2,
  parameter int ARB_MODE    = 0
) (
  input  logic            clock,
  input  logic            reset,
  mem_arbiter_ws_if.slave bus
);
  localparam int                LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              gnt_mem_q;
  logic              last_mem_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              any_req, pick_mem, in_access;
  logic [LANES-1:0]  lane_en;

  assign any_req   = bus.if_req | bus.mem_req;
  // Under contention round-robin hands the grant to whoever did not get the last one.
  assign pick_mem  = bus.mem_req & (~bus.if_req | (ARB_MODE == 0) | ~last_mem_q);
  assign in_access = (state_q == ACCESS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      gnt_mem_q   <= 1'b0;
      last_mem_q  <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (any_req) begin
          cnt_q      <= 4'(WAIT_STATES);
          gnt_mem_q  <= pick_mem;
          last_mem_q <= pick_mem;
          if (pick_mem) begin
            addr_q  <= bus.mem_addr & AMASK;
            rw_q    <= bus.mem_rw;
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_be;
          end else begin
            // Fetch is read-only; write data and enables are left as they were.
            addr_q <= bus.if_addr & AMASK;
            rw_q   <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
          else if (!rw_q) begin
            if (gnt_mem_q) mem_rdata_q <= bus.ram_rdata;
            else           if_rdata_q  <= bus.ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  mem_arbiter_ws_lane u_lane [LANES-1:0] (
    .access (in_access),
    .wr     (rw_q),
    .be     (be_q),
    .en     (lane_en)
  );

  assign bus.ram_addr  = addr_q;
  assign bus.ram_rw    = in_access & rw_q;
  assign bus.ram_en    = lane_en;
  assign bus.ram_wdata = wdata_q;

  assign bus.if_ack    = (state_q == ACK) & ~gnt_mem_q;
  assign bus.mem_ack   = (state_q == ACK) &  gnt_mem_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_stall  = bus.if_req  & ~bus.if_ack;
  assign bus.mem_stall = bus.mem_req & ~bus.mem_ack;
endmodule

// File: tb/tb_mem_arbiter_ws.sv
// Directed bench for mem_arbiter_ws: dut_a (32-bit, 2 wait states, fixed priority) and
// dut_b (64-bit, 0 wait states, round-robin), each backed by a small RAM model and a scoreboard.
module tb_mem_arbiter_ws;
  logic clk, rst;
  int   npass = 0, ntot = 0;

  typedef struct {
    logic        port;   // 1 = memory port, 0 = fetch
    logic        ck;     // compare read data
    logic [63:0] data;
  } exp_t;
  exp_t qa[$], qb[$];

  mem_arbiter_ws_if #(.DATA_W(32), .ADDR_W(32)) ba ();
  mem_arbiter_ws_if #(.DATA_W(64), .ADDR_W(32)) bb ();

  mem_arbiter_ws #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(2), .ARB_MODE(0)) dut_a (
    .clock (clk), .reset (rst), .bus (ba)
  );
  mem_arbiter_ws #(.DATA_W(64), .ADDR_W(32), .WAIT_STATES(0), .ARB_MODE(1)) dut_b (
    .clock (clk), .reset (rst), .bus (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_a(int i);
    return (i == 4) ? 32'h2401_0005 : {16'hC0DE, 16'(i)};
  endfunction
  function automatic logic [63:0] init_b(int i);
    return {16'hFEED, 16'(i), 16'hBEEF, 16'(i)};
  endfunction

  // RAM models: reload a known pattern while reset is high, byte-lane writes otherwise
  logic [31:0] ram_a [64];
  logic [63:0] ram_b [64];
  assign ba.ram_rdata = ram_a[ba.ram_addr[7:2]];
  assign bb.ram_rdata = ram_b[bb.ram_addr[8:3]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        ram_a[i] <= init_a(i);
        ram_b[i] <= init_b(i);
      end
    end else begin
      if (ba.ram_rw)
        for (int i = 0; i < 4; i++)
          if (ba.ram_en[i]) ram_a[ba.ram_addr[7:2]][8*i +: 8] <= ba.ram_wdata[8*i +: 8];
      if (bb.ram_rw)
        for (int i = 0; i < 8; i++)
          if (bb.ram_en[i]) ram_b[bb.ram_addr[8:3]][8*i +: 8] <= bb.ram_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_cmp(input string tag, input bit have, input exp_t e, input logic port,
                        input logic [63:0] rd);
    chk({tag, "_expected"}, 64'(have), 64'd1);
    if (have) begin
      chk({tag, "_port"}, 64'(port), 64'(e.port));
      if (e.ck) chk({tag, "_data"}, rd, e.data);
    end
  endtask

  // Scoreboard: every ack pops the oldest expectation of that DUT
  always @(negedge clk) begin
    exp_t e;
    bit   h;
    e = '{default: '0};
    if (ba.if_ack) begin
      h = qa.size() > 0; if (h) e = qa.pop_front();
      sb_cmp("sb_a_if", h, e, 1'b0, 64'(ba.if_rdata));
    end
    if (ba.mem_ack) begin
      h = qa.size() > 0; if (h) e = qa.pop_front();
      sb_cmp("sb_a_mem", h, e, 1'b1, 64'(ba.mem_rdata));
    end
    if (bb.if_ack) begin
      h = qb.size() > 0; if (h) e = qb.pop_front();
      sb_cmp("sb_b_if", h, e, 1'b0, bb.if_rdata);
    end
    if (bb.mem_ack) begin
      h = qb.size() > 0; if (h) e = qb.pop_front();
      sb_cmp("sb_b_mem", h, e, 1'b1, bb.mem_rdata);
    end
  end

  task automatic a_mem(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic ck, input logic [31:0] ex,
                       output logic [3:0] en0, output int lat);
    @(negedge clk);
    ba.mem_req = 1'b1; ba.mem_rw = rw; ba.mem_addr = addr; ba.mem_wdata = wd; ba.mem_be = be;
    qa.push_back('{1'b1, ck, 64'(ex)});
    lat = 0; en0 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) en0 = ba.ram_en;
      if (ba.mem_ack) begin lat = c; break; end
    end
    ba.mem_req = 1'b0; ba.mem_rw = 1'b0;
  endtask

  task automatic a_if(input logic [31:0] addr, input logic [31:0] ex,
                      output logic [3:0] en0, output int lat);
    @(negedge clk);
    ba.if_req = 1'b1; ba.if_addr = addr;
    qa.push_back('{1'b0, 1'b1, 64'(ex)});
    lat = 0; en0 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) en0 = ba.ram_en;
      if (ba.if_ack) begin lat = c; break; end
    end
    ba.if_req = 1'b0;
  endtask

  task automatic b_if(input logic [31:0] addr, input logic [63:0] ex,
                      output logic [7:0] en0, output logic [31:0] addr0, output int lat);
    @(negedge clk);
    bb.if_req = 1'b1; bb.if_addr = addr;
    qb.push_back('{1'b0, 1'b1, ex});
    lat = 0; en0 = '0; addr0 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin en0 = bb.ram_en; addr0 = bb.ram_addr; end
      if (bb.if_ack) begin lat = c; break; end
    end
    bb.if_req = 1'b0;
  endtask

  initial begin
    logic [3:0]  en4;
    logic [7:0]  en8;
    logic [31:0] a0;
    int          lat, nm, nf;
    int          tack[3];

    rst = 1'b1;
    ba.if_req = 0; ba.if_addr = '0; ba.mem_req = 0; ba.mem_rw = 0;
    ba.mem_addr = '0; ba.mem_wdata = '0; ba.mem_be = '0;
    bb.if_req = 0; bb.if_addr = '0; bb.mem_req = 0; bb.mem_rw = 0;
    bb.mem_addr = '0; bb.mem_wdata = '0; bb.mem_be = '0;
    repeat (2) @(negedge clk);

    chk("rst_ram_en",   64'(ba.ram_en),    64'h0);
    chk("rst_ram_rw",   64'(ba.ram_rw),    64'h0);
    chk("rst_ram_addr", 64'(ba.ram_addr),  64'h0);
    chk("rst_ram_wd",   64'(ba.ram_wdata), 64'h0);
    chk("rst_acks",     64'({ba.if_ack, ba.mem_ack, bb.if_ack, bb.mem_ack}), 64'h0);
    chk("rst_rdata",    64'(ba.if_rdata | ba.mem_rdata), 64'h0);
    chk("rst_b_en",     64'(bb.ram_en),    64'h0);
    rst = 1'b0;

    // Fetch read with 2 wait states: three enabled cycles, ack on the 4th
    @(negedge clk);
    ba.if_req = 1'b1; ba.if_addr = 32'h0000_0010;
    qa.push_back('{1'b0, 1'b1, 64'h2401_0005});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t1_en",    64'(ba.ram_en),   64'hF);
      chk("t1_noack", 64'(ba.if_ack),   64'h0);
      chk("t1_stall", 64'(ba.if_stall), 64'h1);
    end
    chk("t1_addr", 64'(ba.ram_addr), 64'h10);
    chk("t1_rw",   64'(ba.ram_rw),   64'h0);
    @(negedge clk);
    chk("t1_ack",       64'(ba.if_ack),   64'h1);
    chk("t1_en_ack",    64'(ba.ram_en),   64'h0);
    chk("t1_stall_ack", 64'(ba.if_stall), 64'h0);
    ba.if_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", 64'(ba.if_ack),   64'h0);
    chk("t1_rd_hold",   64'(ba.if_rdata), 64'h2401_0005);

    // Partial write: lanes 0/1 only, aligned address on the RAM side
    @(negedge clk);
    ba.mem_req = 1'b1; ba.mem_rw = 1'b1; ba.mem_addr = 32'h0000_0022;
    ba.mem_wdata = 32'hAABB_CCDD; ba.mem_be = 4'b0011;
    qa.push_back('{1'b1, 1'b0, 64'h0});
    @(negedge clk);
    chk("t2_addr", 64'(ba.ram_addr),  64'h20);
    chk("t2_rw",   64'(ba.ram_rw),    64'h1);
    chk("t2_en",   64'(ba.ram_en),    64'h3);
    chk("t2_wd",   64'(ba.ram_wdata), 64'hAABB_CCDD);
    ba.mem_addr = 32'h0000_00FC; ba.mem_be = 4'b1111;   // must be ignored mid-access
    repeat (2) @(negedge clk);
    chk("t2_latched", 64'(ba.ram_en), 64'h3);
    @(negedge clk);
    chk("t2_ack",   64'(ba.mem_ack),   64'h1);
    chk("t2_stall", 64'(ba.mem_stall), 64'h0);
    chk("t2_ram",   64'(ram_a[8]),     64'hC0DE_CCDD);
    chk("t2_other", 64'(ram_a[63]),    64'(init_a(63)));
    ba.mem_req = 1'b0; ba.mem_rw = 1'b0;
    @(negedge clk);
    chk("t2_ack_pulse", 64'(ba.mem_ack), 64'h0);

    a_mem(1'b0, 32'h20, 32'h0, 4'b0000, 1'b1, 32'hC0DE_CCDD, en4, lat);
    chk("t2_rb_en",  64'(en4), 64'hF);
    chk("t2_rb_lat", 64'(lat), 64'd4);

    // Write with no byte enables: full sequence, nothing changes
    a_mem(1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, en4, lat);
    chk("t3_en",  64'(en4),      64'h0);
    chk("t3_lat", 64'(lat),      64'd4);
    chk("t3_ram", 64'(ram_a[9]), 64'(init_a(9)));

    // Fixed priority: memory port wins three times, fetch waits
    @(negedge clk);
    ba.mem_req = 1'b1; ba.mem_rw = 1'b0; ba.mem_addr = 32'h40;
    ba.if_req = 1'b1; ba.if_addr = 32'h50;
    for (int i = 0; i < 3; i++) qa.push_back('{1'b1, 1'b1, 64'(init_a(16 + i))});
    qa.push_back('{1'b0, 1'b1, 64'(init_a(20))});
    nm = 0; nf = 0;
    for (int cyc = 0; cyc < 60 && nf == 0; cyc++) begin
      @(negedge clk);
      if (nm < 3) chk("t4_if_stall", 64'(ba.if_stall), 64'h1);
      if (ba.mem_ack) begin
        nm++;
        if (nm < 3) ba.mem_addr = 32'h40 + 32'(4 * nm);
        else        ba.mem_req = 1'b0;
      end
      if (ba.if_ack) begin nf++; ba.if_req = 1'b0; end
    end
    chk("t4_nmem", 64'(nm), 64'd3);
    chk("t4_nif",  64'(nf), 64'd1);

    // Round-robin on dut_b: mem, fetch, mem, fetch
    @(negedge clk);
    bb.mem_req = 1'b1; bb.mem_addr = 32'h08;
    bb.if_req = 1'b1;  bb.if_addr = 32'h10;
    qb.push_back('{1'b1, 1'b1, init_b(1)});
    qb.push_back('{1'b0, 1'b1, init_b(2)});
    qb.push_back('{1'b1, 1'b1, init_b(3)});
    qb.push_back('{1'b0, 1'b1, init_b(4)});
    nm = 0; nf = 0;
    for (int cyc = 0; cyc < 40 && (nm < 2 || nf < 2); cyc++) begin
      @(negedge clk);
      if (bb.mem_ack) begin
        nm++;
        if (nm == 1) bb.mem_addr = 32'h18; else bb.mem_req = 1'b0;
      end
      if (bb.if_ack) begin
        nf++;
        if (nf == 1) bb.if_addr = 32'h20; else bb.if_req = 1'b0;
      end
    end
    chk("t5_nmem", 64'(nm), 64'd2);
    chk("t5_nif",  64'(nf), 64'd2);

    // 64-bit read from an unaligned address
    b_if(32'h0000_000F, init_b(1), en8, a0, lat);
    chk("t6_en",   64'(en8), 64'hFF);
    chk("t6_addr", 64'(a0),  64'h08);
    chk("t6_lat",  64'(lat), 64'd2);

    // Zero wait states, fetch held: an ack every third cycle
    @(negedge clk);
    bb.if_req = 1'b1; bb.if_addr = 32'h30;
    for (int i = 0; i < 3; i++) qb.push_back('{1'b0, 1'b1, init_b(6)});
    nf = 0;
    for (int cyc = 0; cyc < 30 && nf < 3; cyc++) begin
      @(negedge clk);
      if (bb.if_ack) begin
        tack[nf] = cyc; nf++;
        if (nf == 3) bb.if_req = 1'b0;
      end
    end
    chk("t7_nif", 64'(nf), 64'd3);
    chk("t7_gap1", 64'(tack[1] - tack[0]), 64'd3);
    chk("t7_gap2", 64'(tack[2] - tack[1]), 64'd3);

    // Reset in the middle of a write access
    @(negedge clk);
    ba.mem_req = 1'b1; ba.mem_rw = 1'b1; ba.mem_addr = 32'h60;
    ba.mem_wdata = 32'h0BAD_0BAD; ba.mem_be = 4'hF;
    repeat (2) @(negedge clk);
    chk("t8_mid_rw", 64'(ba.ram_rw), 64'h1);
    rst = 1'b1;
    #1;
    chk("t8_en",    64'(ba.ram_en),    64'h0);
    chk("t8_rw",    64'(ba.ram_rw),    64'h0);
    chk("t8_addr",  64'(ba.ram_addr),  64'h0);
    chk("t8_wd",    64'(ba.ram_wdata), 64'h0);
    chk("t8_ack",   64'(ba.mem_ack),   64'h0);
    chk("t8_rdata", 64'(ba.if_rdata | ba.mem_rdata), 64'h0);
    chk("t8_b_rd",  bb.if_rdata | bb.mem_rdata, 64'h0);
    ba.mem_req = 1'b0; ba.mem_rw = 1'b0; ba.mem_be = '0;
    @(negedge clk);
    rst = 1'b0;
    a_if(32'h10, 32'h2401_0005, en4, lat);
    chk("t8_after_en",  64'(en4), 64'hF);
    chk("t8_after_lat", 64'(lat), 64'd4);

    repeat (2) @(negedge clk);
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
